// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle between requesters/memory (master side) and the arbiter (slave side).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              stall_if;

    logic              ds_req;
    logic              ds_we;
    logic [ADDR_W-1:0] ds_addr;
    logic [DATA_W-1:0] ds_wdata;
    logic              ds_gnt;
    logic              ds_valid;
    logic [DATA_W-1:0] ds_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    // Master is the requesting pipeline plus the memory macro returning read data.
    modport master (
        output if_req, if_addr, ds_req, ds_we, ds_addr, ds_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, stall_if, ds_gnt, ds_valid, ds_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  if_req, if_addr, ds_req, ds_we, ds_addr, ds_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, stall_if, ds_gnt, ds_valid, ds_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter_starve_guard.sv
// Saturating count of consecutive data wins against a waiting fetch.
// Only built when ARB_STARVE_GUARD_EN is defined.
`ifdef ARB_STARVE_GUARD_EN
module mem_arb_starve_guard
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_if_req,
    input  logic i_data_gnt,
    input  logic i_fetch_gnt,
    output logic o_force_fetch
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_if_req || i_fetch_gnt) begin
            r_cnt <= '0;
        end else if (i_data_gnt && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_force_fetch = (r_cnt == LIMIT);
endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-port memory with fixed-latency accesses.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT data wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t            r_state;
    owner_t            r_owner;
    logic [CNT_W-1:0]  r_wait;
    logic              r_if_gnt;
    logic              r_if_valid;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_ds_gnt;
    logic              r_ds_valid;
    logic [DATA_W-1:0] r_ds_rdata;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic w_force_fetch;
    logic w_pick_data;
    logic w_grant_data;
    logic w_grant_fetch;

`ifdef ARB_STARVE_GUARD_EN
    mem_arb_starve_guard #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_guard (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_if_req      (bus.if_req),
        .i_data_gnt    (w_grant_data),
        .i_fetch_gnt   (w_grant_fetch),
        .o_force_fetch (w_force_fetch)
    );
`else
    assign w_force_fetch = 1'b0;
`endif

    // Data wins ties unless the guard says fetch has waited long enough.
    assign w_pick_data   = bus.ds_req & ~(bus.if_req & w_force_fetch);
    assign w_grant_data  = (r_state == IDLE) & w_pick_data;
    assign w_grant_fetch = (r_state == IDLE) & bus.if_req & ~w_pick_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= OWN_FETCH;
            r_wait      <= '0;
            r_if_gnt    <= 1'b0;
            r_if_valid  <= 1'b0;
            r_if_rdata  <= '0;
            r_ds_gnt    <= 1'b0;
            r_ds_valid  <= 1'b0;
            r_ds_rdata  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_if_gnt   <= 1'b0;
            r_ds_gnt   <= 1'b0;
            r_if_valid <= 1'b0;
            r_ds_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_data) begin
                        r_state     <= BUSY;
                        r_owner     <= OWN_DATA;
                        r_wait      <= WAIT_LOAD;
                        r_mem_we    <= bus.ds_we;
                        r_mem_addr  <= bus.ds_addr;
                        r_mem_wdata <= bus.ds_wdata;
                        r_ds_gnt    <= 1'b1;
                    end else if (w_grant_fetch) begin
                        r_state    <= BUSY;
                        r_owner    <= OWN_FETCH;
                        r_wait     <= WAIT_LOAD;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= bus.if_addr;
                        r_if_gnt   <= 1'b1;
                    end
                end
                BUSY: begin
                    if (r_wait != '0) begin
                        r_wait <= r_wait - CNT_W'(1);
                    end else begin
                        r_state <= IDLE;
                        if (r_owner == OWN_DATA) begin
                            r_ds_valid <= 1'b1;
                            if (!r_mem_we) r_ds_rdata <= bus.mem_rdata;
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= bus.mem_rdata;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.if_gnt    = r_if_gnt;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.stall_if  = bus.if_req & ~r_if_valid;
    assign bus.ds_gnt    = r_ds_gnt;
    assign bus.ds_valid  = r_ds_valid;
    assign bus.ds_rdata  = r_ds_rdata;
    assign bus.mem_en    = (r_state == BUSY);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = (r_state == BUSY);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with WAIT_CYCLES=2, STARVE_LIMIT=3.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic [7:0] tb_mem [256];
    logic [4:0] seq;
    int         n_gnt;
    logic       saw_valid;

    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_port_arbiter #(
        .ADDR_W       (8),
        .DATA_W       (8),
        .WAIT_CYCLES  (2),
        .STARVE_LIMIT (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mem_rdata = tb_mem[bus.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_if_gnt"},   bus.if_gnt,   0);
        check_val({tag, "_ds_gnt"},   bus.ds_gnt,   0);
        check_val({tag, "_if_valid"}, bus.if_valid, 0);
        check_val({tag, "_ds_valid"}, bus.ds_valid, 0);
        check_val({tag, "_mem_en"},   bus.mem_en,   0);
        check_val({tag, "_busy"},     bus.busy,     0);
        check_val({tag, "_if_rdata"}, bus.if_rdata, 0);
        check_val({tag, "_ds_rdata"}, bus.ds_rdata, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
        tb_mem[8'h10] = 8'hA5;
        tb_mem[8'h11] = 8'h77;
        tb_mem[8'h80] = 8'hC3;
        tb_mem[8'h50] = 8'hE1;
        tb_mem[8'h20] = 8'h12;
        tb_mem[8'h21] = 8'h34;

        rst_n        = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = 8'h00;
        bus.ds_req   = 1'b0;
        bus.ds_we    = 1'b0;
        bus.ds_addr  = 8'h00;
        bus.ds_wdata = 8'h00;

        // reset state
        step();
        step();
        check_idle_outputs("rst");
        check_val("rst_mem_we",   bus.mem_we,   0);
        check_val("rst_mem_addr", bus.mem_addr, 0);
        check_val("rst_stall_if", bus.stall_if, 0);
        rst_n = 1'b1;
        step();
        step();
        check_idle_outputs("post_rst");

        // fetch read
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h10;
        #1;
        check_val("fr_stall_pre", bus.stall_if, 1);
        step();
        check_val("fr_if_gnt",   bus.if_gnt,   1);
        check_val("fr_ds_gnt",   bus.ds_gnt,   0);
        check_val("fr_mem_en0",  bus.mem_en,   1);
        check_val("fr_busy",     bus.busy,     1);
        check_val("fr_mem_addr", bus.mem_addr, 8'h10);
        check_val("fr_mem_we",   bus.mem_we,   0);
        check_val("fr_stall0",   bus.stall_if, 1);
        step();
        check_val("fr_if_gnt1",  bus.if_gnt,   0);
        check_val("fr_mem_en1",  bus.mem_en,   1);
        check_val("fr_valid1",   bus.if_valid, 0);
        check_val("fr_stall1",   bus.stall_if, 1);
        step();
        check_val("fr_valid2",   bus.if_valid, 1);
        check_val("fr_rdata",    bus.if_rdata, 8'hA5);
        check_val("fr_mem_en2",  bus.mem_en,   0);
        check_val("fr_stall2",   bus.stall_if, 0);
        bus.if_req = 1'b0;
        step();
        check_val("fr_valid3",   bus.if_valid, 0);
        check_val("fr_if_gnt3",  bus.if_gnt,   0);
        check_val("fr_busy3",    bus.busy,     0);

        // simultaneous fetch + data write
        bus.if_req   = 1'b1;
        bus.if_addr  = 8'h11;
        bus.ds_req   = 1'b1;
        bus.ds_we    = 1'b1;
        bus.ds_addr  = 8'h80;
        bus.ds_wdata = 8'h3C;
        step();
        check_val("sim_ds_gnt",    bus.ds_gnt,    1);
        check_val("sim_if_gnt0",   bus.if_gnt,    0);
        check_val("sim_mem_we",    bus.mem_we,    1);
        check_val("sim_mem_addr",  bus.mem_addr,  8'h80);
        check_val("sim_mem_wdata", bus.mem_wdata, 8'h3C);
        bus.ds_addr  = 8'h99;
        bus.ds_wdata = 8'hFF;
        step();
        check_val("sim_addr_held",  bus.mem_addr,  8'h80);
        check_val("sim_wdata_held", bus.mem_wdata, 8'h3C);
        step();
        check_val("sim_ds_valid", bus.ds_valid, 1);
        check_val("sim_ds_rdata", bus.ds_rdata, 0);
        bus.ds_req = 1'b0;
        step();
        check_val("sim_if_gnt",   bus.if_gnt,   1);
        check_val("sim_f_we",     bus.mem_we,   0);
        check_val("sim_f_addr",   bus.mem_addr, 8'h11);
        step();
        step();
        check_val("sim_if_valid", bus.if_valid, 1);
        check_val("sim_if_rdata", bus.if_rdata, 8'h77);
        bus.if_req = 1'b0;
        step();

        // starvation: both held, record grant owners (1 = fetch), oldest in bit 0
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h40;
        bus.ds_req  = 1'b1;
        bus.ds_we   = 1'b0;
        bus.ds_addr = 8'h30;
        seq   = '0;
        n_gnt = 0;
        for (int c = 0; c < 13; c++) begin
            step();
            if (bus.ds_gnt || bus.if_gnt) begin
                seq = {bus.if_gnt, seq[4:1]};
                n_gnt++;
            end
        end
        check_val("stv_n_gnt", n_gnt, 5);
`ifdef ARB_STARVE_GUARD_EN
        check_val("stv_seq", seq, 5'b01000);
`else
        check_val("stv_seq", seq, 5'b00000);
`endif
        bus.if_req = 1'b0;
        bus.ds_req = 1'b0;
        step();
        step();
        step();
        check_val("stv_drain_busy", bus.busy, 0);

        // reset in the middle of a data read
        bus.ds_req  = 1'b1;
        bus.ds_we   = 1'b0;
        bus.ds_addr = 8'h50;
        step();
        check_val("rma_ds_gnt", bus.ds_gnt, 1);
        bus.ds_req = 1'b0;
        step();
        check_val("rma_mem_en_pre", bus.mem_en, 1);
        rst_n = 1'b0;
        #1;
        check_val("rma_mem_en", bus.mem_en, 0);
        check_val("rma_busy",   bus.busy,   0);
        saw_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            saw_valid = saw_valid | bus.ds_valid;
        end
        rst_n = 1'b1;
        step();
        saw_valid = saw_valid | bus.ds_valid;
        check_val("rma_no_valid", saw_valid, 0);
        check_val("rma_ds_rdata", bus.ds_rdata, 0);
        bus.ds_req = 1'b1;
        step();
        check_val("rma_regnt", bus.ds_gnt, 1);
        bus.ds_req = 1'b0;
        step();
        step();
        check_val("rma_valid", bus.ds_valid, 1);
        check_val("rma_rdata", bus.ds_rdata, 8'hE1);
        step();

        // back-to-back data reads
        bus.ds_req  = 1'b1;
        bus.ds_we   = 1'b0;
        bus.ds_addr = 8'h20;
        step();
        check_val("b2b_gnt0",  bus.ds_gnt,   1);
        check_val("b2b_addr0", bus.mem_addr, 8'h20);
        bus.ds_addr = 8'h21;
        step();
        check_val("b2b_gap1", bus.ds_gnt, 0);
        step();
        check_val("b2b_valid0", bus.ds_valid, 1);
        check_val("b2b_rdata0", bus.ds_rdata, 8'h12);
        check_val("b2b_gap2",   bus.ds_gnt,   0);
        step();
        check_val("b2b_gnt1",  bus.ds_gnt,   1);
        check_val("b2b_addr1", bus.mem_addr, 8'h21);
        step();
        step();
        check_val("b2b_valid1", bus.ds_valid, 1);
        check_val("b2b_rdata1", bus.ds_rdata, 8'h34);
        bus.ds_req = 1'b0;
        step();
        check_val("b2b_no_gnt", bus.ds_gnt, 0);
        check_val("b2b_idle",   bus.busy,   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
